video_pixel_sink: RTL and testbench
===================================

// Module: video_pixel_sink
// PURPOSE
//  Receiving end of the DPU video-out path: accepts 24-bit pixel commands {X,Y,Colour} strobed out
//  of the DPU, buffers them in a small FIFO and writes them into the framebuffer RAM port.
//  Also performs a hardware clear-screen fill. Sits between the DPU and the framebuffer/scan-out.
// PARAMETERS
//  FB_W        160  visible framebuffer width in pixels (X range 0..FB_W-1)
//  FB_H        120  visible framebuffer height in pixels (Y range 0..FB_H-1)
//  ADDR_W      15   framebuffer address width; must satisfy 2**ADDR_W >= FB_W*FB_H
//  FIFO_DEPTH  4    pixel FIFO entries, power of two, >= 2
// PORTS
//  clk           in   1       system clock, all logic on rising edge
//  reset         in   1       synchronous, active-high reset
//  kbus_in       in   24      pixel command: [23:16]=X, [15:8]=Y, [7:0]=Colour
//  out_enable    in   1       kbus_in valid this cycle; accepted only when pix_ready=1
//  pix_ready     out  1       FIFO can accept a pixel this cycle
//  clear_req     in   1       one-cycle request: fill whole framebuffer with clear_colour
//  clear_colour  in   8       fill colour, sampled in the cycle clear_req is accepted
//  fb_we         out  1       framebuffer write strobe (registered)
//  fb_addr       out  ADDR_W  write address = Y*FB_W + X (registered)
//  fb_wdata      out  8       write colour (registered)
//  busy          out  1       1 while FIFO non-empty or FSM not IDLE
//  clipped_cnt   out  8       count of dropped out-of-range pixels, saturates at 255
//  overflow      out  1       sticky: out_enable seen while pix_ready=0
// BEHAVIOUR
//  - Reset: FIFO empty, FSM=IDLE, fb_we=0, fb_addr=0, fb_wdata=0, clipped_cnt=0, overflow=0,
//    busy=0, pix_ready=1 in the cycle after reset deasserts. Reset mid-clear abandons the fill.
//  - pix_ready = !fifo_full, from registered count only (a pop in the same cycle does not free space).
//  - Push: out_enable && pix_ready at edge k stores kbus_in. out_enable && !pix_ready: pixel dropped,
//    overflow set to 1 until reset. Push and pop in same cycle (non-full): count unchanged.
//  - FSM states: IDLE, DRAIN, CLEAR.
//    IDLE : clear_req -> CLEAR; else FIFO non-empty -> DRAIN.
//    DRAIN: pop one entry per cycle; clear_req -> CLEAR after the current pop (entry not lost);
//           FIFO becomes empty with no clear_req -> IDLE.
//    CLEAR: counter 0..FB_W*FB_H-1, one write per cycle (fb_addr=counter, fb_wdata=latched
//           clear_colour); after last address -> DRAIN if FIFO non-empty, else IDLE.
//           clear_req while in CLEAR is ignored. Pixels keep being accepted into FIFO during CLEAR.
//  - Pixel write: popped entry with X<FB_W and Y<FB_H drives fb_we=1, fb_addr=Y*FB_W+X (ADDR_W bits,
//    no wrap), fb_wdata=Colour in the cycle after the pop. Otherwise fb_we=0 and clipped_cnt+1 (sat).
//  - Latency: push at edge k into empty FIFO in IDLE -> fb_we high for the cycle after edge k+2
//    (one cycle to enter DRAIN/pop, one output register). Sustained throughput 1 pixel/cycle.
//  - fb_we is 0 in every cycle with no pop/clear write; fb_addr/fb_wdata hold last value.
//  - busy=1 from the edge a pixel/clear is accepted until the final fb_we cycle has completed.
//  - Pixels are written strictly in acceptance order; clear overwrites only pixels already written.
// STRUCTURE
//  - Shared package video_pkg: FB_W/FB_H defaults, KBUS field positions (X_MSB..COL_LSB),
//    FSM state encoding (IDLE/DRAIN/CLEAR), colour width constant.
//  - Sub-module pixel_fifo (synchronous FIFO, DEPTH/WIDTH params, push/pop/full/empty/count).
//  - Top holds FSM, clear counter, address multiply (constant FB_W), clip check, counters.
// TESTING
//  1 Reset then out_enable with kbus_in=24'h05_03_AA -> exactly one fb_we, fb_addr=485, fb_wdata=8'hAA,
//    2 cycles after acceptance; busy returns to 0.
//  2 Burst of 6 back-to-back pixels, FIFO_DEPTH=4, drain active -> all written in order, overflow=0;
//    hold FSM in CLEAR and push 5 -> 5th dropped, pix_ready=0, overflow=1 sticky.
//  3 kbus_in X=160,Y=0 then X=0,Y=120 then X=159,Y=119 -> two drops, clipped_cnt=2, one write addr 19199.
//  4 clear_req with clear_colour=8'h1F -> 19200 consecutive fb_we cycles, addr 0..19199, data 1F;
//    second clear_req mid-fill ignored; pixels pushed during fill written afterwards, after addr 19199.
//  5 Assert reset at clear address 1000 -> fb_we=0 next cycle, all outputs at reset values, FIFO empty.
//  6 Push 256+ out-of-range pixels -> clipped_cnt saturates at 255, no fb_we ever asserted.

Source files
------------

// File: rtl/video_pixel_sink_pkg.sv
// Shared definitions for the DPU video-out pixel sink: framebuffer defaults,
// pixel command layout, colour width and FSM state encoding.
// Ports: none (package).
package video_pkg;

  localparam int FB_W_DEF = 160;
  localparam int FB_H_DEF = 120;
  localparam int COL_W    = 8;
  localparam int KBUS_W   = 24;

  // Bit positions of the fields inside a 24-bit pixel command.
  localparam int X_MSB   = 23;
  localparam int X_LSB   = 16;
  localparam int Y_MSB   = 15;
  localparam int Y_LSB   = 8;
  localparam int COL_MSB = 7;
  localparam int COL_LSB = 0;

  typedef struct packed {
    logic [X_MSB-X_LSB:0]     x;
    logic [Y_MSB-Y_LSB:0]     y;
    logic [COL_MSB-COL_LSB:0] col;
  } kbus_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } sink_state_t;

endpackage

// File: rtl/video_pixel_sink_if.sv
// Pixel command / clear request bundle between the DPU (master) and the sink (slave).
// Signals: kbus_in (X,Y,Colour), out_enable (valid), pix_ready (sink can accept),
//          clear_req (one-cycle fill request), clear_colour (fill colour).
interface video_pixel_sink_if;

  logic [video_pkg::KBUS_W-1:0] kbus_in;
  logic                         out_enable;
  logic                         pix_ready;
  logic                         clear_req;
  logic [video_pkg::COL_W-1:0]  clear_colour;

  modport master (
    output kbus_in, out_enable, clear_req, clear_colour,
    input  pix_ready
  );

  modport slave (
    input  kbus_in, out_enable, clear_req, clear_colour,
    output pix_ready
  );

endinterface

// File: rtl/video_pixel_sink_fifo.sv
// Synchronous pixel FIFO, DEPTH (power of two) entries of WIDTH bits.
// Latency: written entry visible on dout the cycle after push; dout shows head combinationally.
// Backpressure: push ignored when full, pop ignored when empty; full comes from the registered count.
// Ports: clk, reset (sync, active-high), push/din, pop/dout, full, empty, count.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/video_pixel_sink.sv
// Pixel sink: buffers DPU pixel commands and writes them to the framebuffer; also does clear-screen fill.
// Latency: pixel pushed into an empty FIFO while idle is written two cycles after acceptance; 1 pixel/cycle sustained.
// Backpressure: pix_ready drops when the FIFO is full; pixels offered then are dropped and overflow is set sticky.
// Ports: clk, reset (sync, active-high), kbus (slave side of video_pixel_sink_if),
//        fb_we/fb_addr/fb_wdata (registered framebuffer write port), busy, clipped_cnt, overflow.
module video_pixel_sink
  import video_pkg::*;
#(
  parameter int FB_W       = FB_W_DEF,
  parameter int FB_H       = FB_H_DEF,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  video_pixel_sink_if.slave    kbus,
  output logic                 fb_we,
  output logic [ADDR_W-1:0]    fb_addr,
  output logic [COL_W-1:0]     fb_wdata,
  output logic                 busy,
  output logic [7:0]           clipped_cnt,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_W * FB_H - 1);

  sink_state_t          state, state_n;
  logic                 push;
  logic                 pop;
  logic                 clr_load;
  logic [ADDR_W-1:0]    clr_cnt;
  logic [COL_W-1:0]     clr_col;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [KBUS_W-1:0]    fifo_dout;
  kbus_t                pop_pix;
  logic                 in_range;
  logic [ADDR_W-1:0]    pix_addr;

  assign kbus.pix_ready = !fifo_full;
  assign push           = kbus.out_enable && !fifo_full;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KBUS_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (kbus.kbus_in),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pop_pix  = kbus_t'(fifo_dout);
  assign in_range = (32'(pop_pix.x) < FB_W) && (32'(pop_pix.y) < FB_H);
  assign pix_addr = ADDR_W'(pop_pix.y) * ADDR_W'(FB_W) + ADDR_W'(pop_pix.x);

  // fb_we is included so busy covers the final output-register cycle.
  assign busy = !fifo_empty || (state != ST_IDLE) || fb_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    clr_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (kbus.clear_req) begin
          state_n  = ST_CLEAR;
          clr_load = 1'b1;
        end else if (!fifo_empty) begin
          state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        pop = !fifo_empty;
        // The pop of this cycle still completes before the fill starts.
        if (kbus.clear_req) begin
          state_n  = ST_CLEAR;
          clr_load = 1'b1;
        end else if (!push && (fifo_empty || fifo_count == CNT_W'(1))) begin
          state_n = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt == CLR_LAST) begin
          state_n = (!fifo_empty || push) ? ST_DRAIN : ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt <= '0;
      clr_col <= '0;
    end else if (clr_load) begin
      clr_cnt <= '0;
      clr_col <= kbus.clear_colour;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_wdata    <= '0;
      clipped_cnt <= '0;
      overflow    <= 1'b0;
    end else begin
      fb_we <= 1'b0;
      if (state == ST_CLEAR) begin
        fb_we    <= 1'b1;
        fb_addr  <= clr_cnt;
        fb_wdata <= clr_col;
      end else if (pop) begin
        if (in_range) begin
          fb_we    <= 1'b1;
          fb_addr  <= pix_addr;
          fb_wdata <= pop_pix.col;
        end else if (clipped_cnt != 8'hFF) begin
          clipped_cnt <= clipped_cnt + 8'd1;
        end
      end
      if (kbus.out_enable && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_pixel_sink.sv
// Directed bench for video_pixel_sink: reset state, single-pixel latency, bursts and backpressure,
// clipping, clear-screen fill, reset during fill and clipped-count saturation.
module tb_video_pixel_sink;

  logic        clk;
  logic        reset;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        busy;
  logic [7:0]  clipped_cnt;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [14:0] wq_addr[$];
  logic [7:0]  wq_dat[$];
  int          wq_cyc[$];

  video_pixel_sink_if vif();

  video_pixel_sink #(
    .FB_W       (160),
    .FB_H       (120),
    .ADDR_W     (15),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .kbus        (vif.slave),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_wdata    (fb_wdata),
    .busy        (busy),
    .clipped_cnt (clipped_cnt),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every framebuffer write with the cycle it occurred in.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fb_we === 1'b1) begin
      wq_addr.push_back(fb_addr);
      wq_dat.push_back(fb_wdata);
      wq_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_q();
    wq_addr.delete();
    wq_dat.delete();
    wq_cyc.delete();
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int bad;
    int n;
    int idx;

    reset            = 1'b1;
    vif.kbus_in      = '0;
    vif.out_enable   = 1'b0;
    vif.clear_req    = 1'b0;
    vif.clear_colour = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_pix_ready", 32'(vif.pix_ready), 1);
    chk("rst_fb_we",     32'(fb_we), 0);
    chk("rst_fb_addr",   32'(fb_addr), 0);
    chk("rst_fb_wdata",  32'(fb_wdata), 0);
    chk("rst_clipped",   32'(clipped_cnt), 0);
    chk("rst_overflow",  32'(overflow), 0);
    chk("rst_busy",      32'(busy), 0);

    // Single pixel X=5 Y=3 -> addr 3*160+5 = 485, two cycles after acceptance
    clr_q();
    vif.kbus_in    = 24'h0503AA;
    vif.out_enable = 1'b1;
    tick();
    vif.out_enable = 1'b0;
    chk("t1_busy_accept", 32'(busy), 1);
    chk("t1_we_k",        32'(fb_we), 0);
    tick();
    chk("t1_we_k1",       32'(fb_we), 0);
    tick();
    chk("t1_we_k2",       32'(fb_we), 1);
    chk("t1_addr",        32'(fb_addr), 485);
    chk("t1_data",        32'(fb_wdata), 32'hAA);
    tick();
    chk("t1_we_after",    32'(fb_we), 0);
    chk("t1_busy_done",   32'(busy), 0);
    chk("t1_nwrites",     32'(wq_addr.size()), 1);

    // Burst of 6 back-to-back pixels on row 1
    clr_q();
    for (int i = 0; i < 6; i++) begin
      vif.kbus_in    = {8'(i), 8'd1, 8'(8'h10 + i)};
      vif.out_enable = 1'b1;
      tick();
    end
    vif.out_enable = 1'b0;
    wait_idle(50, "t2_idle");
    chk("t2_overflow", 32'(overflow), 0);
    chk("t2_nwrites",  32'(wq_addr.size()), 6);
    if (wq_addr.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("t2_addr%0d", i), 32'(wq_addr[i]), 32'(160 + i));
        chk($sformatf("t2_data%0d", i), 32'(wq_dat[i]),  32'(8'h10 + i));
      end
    end

    // Clear fill with 1F; 5 pixels pushed during the fill (5th dropped); a second clear is ignored
    clr_q();
    vif.clear_req    = 1'b1;
    vif.clear_colour = 8'h1F;
    tick();
    vif.clear_req    = 1'b0;
    vif.clear_colour = 8'h00;
    for (int i = 0; i < 5; i++) begin
      vif.kbus_in    = {8'(i), 8'd2, 8'(8'h40 + i)};
      vif.out_enable = 1'b1;
      if (i == 4) chk("t2_pix_ready_full", 32'(vif.pix_ready), 0);
      tick();
    end
    vif.out_enable = 1'b0;
    chk("t2_overflow_set", 32'(overflow), 1);
    repeat (100) tick();
    vif.clear_req    = 1'b1;
    vif.clear_colour = 8'h55;
    tick();
    vif.clear_req    = 1'b0;
    vif.clear_colour = 8'h00;
    wait_idle(20000, "t4_idle");
    chk("t4_nwrites", 32'(wq_addr.size()), 19204);
    bad = 0;
    n = (wq_addr.size() < 19200) ? wq_addr.size() : 19200;
    for (int i = 0; i < n; i++) begin
      if (wq_addr[i] != 15'(i) || wq_dat[i] != 8'h1F) bad++;
      if (i > 0 && wq_cyc[i] != wq_cyc[i-1] + 1) bad++;
    end
    chk("t4_clear_seq", 32'(bad + (19200 - n)), 0);
    for (int j = 0; j < 4; j++) begin
      idx = 19200 + j;
      if (idx < wq_addr.size()) begin
        chk($sformatf("t4_pix_addr%0d", j), 32'(wq_addr[idx]), 32'(320 + j));
        chk($sformatf("t4_pix_data%0d", j), 32'(wq_dat[idx]),  32'(8'h40 + j));
      end else begin
        chk($sformatf("t4_pix_missing%0d", j), 32'(wq_addr.size()), 32'(idx + 1));
      end
    end
    chk("t2_overflow_sticky", 32'(overflow), 1);

    // Clipping: X=160 and Y=120 dropped, X=159 Y=119 written at 19199
    clr_q();
    vif.out_enable = 1'b1;
    vif.kbus_in    = 24'hA00011;
    tick();
    vif.kbus_in    = 24'h007822;
    tick();
    vif.kbus_in    = 24'h9F7733;
    tick();
    vif.out_enable = 1'b0;
    wait_idle(50, "t3_idle");
    chk("t3_clipped", 32'(clipped_cnt), 2);
    chk("t3_nwrites", 32'(wq_addr.size()), 1);
    if (wq_addr.size() == 1) begin
      chk("t3_addr", 32'(wq_addr[0]), 19199);
      chk("t3_data", 32'(wq_dat[0]), 32'h33);
    end

    // Reset while the fill is at address 1000, with pixels pending in the FIFO
    vif.clear_req    = 1'b1;
    vif.clear_colour = 8'h66;
    tick();
    vif.clear_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vif.kbus_in    = {8'(i), 8'd5, 8'h99};
      vif.out_enable = 1'b1;
      tick();
    end
    vif.out_enable = 1'b0;
    n = 0;
    while (!(fb_we === 1'b1 && fb_addr == 15'd1000) && n < 3000) begin
      tick();
      n++;
    end
    chk("t5_reach1000", 32'(fb_addr), 1000);
    reset = 1'b1;
    tick();
    chk("t5_fb_we",     32'(fb_we), 0);
    chk("t5_fb_addr",   32'(fb_addr), 0);
    chk("t5_fb_wdata",  32'(fb_wdata), 0);
    chk("t5_clipped",   32'(clipped_cnt), 0);
    chk("t5_overflow",  32'(overflow), 0);
    chk("t5_busy",      32'(busy), 0);
    chk("t5_pix_ready", 32'(vif.pix_ready), 1);
    clr_q();
    reset = 1'b0;
    repeat (10) tick();
    chk("t5_no_writes", 32'(wq_addr.size()), 0);
    chk("t5_idle",      32'(busy), 0);

    // 260 out-of-range pixels -> clipped_cnt saturates at 255, no writes
    clr_q();
    for (int i = 0; i < 260; i++) begin
      vif.kbus_in    = {8'd200, 8'(i), 8'h77};
      vif.out_enable = 1'b1;
      tick();
    end
    vif.out_enable = 1'b0;
    wait_idle(100, "t6_idle");
    chk("t6_clipped_sat", 32'(clipped_cnt), 255);
    chk("t6_no_writes",   32'(wq_addr.size()), 0);
    chk("t6_overflow",    32'(overflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
